// File: rtl/norm_pkg.sv
// ============================================================================
// norm_pkg: shared widths and stage payloads for norm_shift16.  Rev 1.0
// ============================================================================
`default_nettype none

package norm_pkg;

  localparam int NORM_WIDTH = 16;
  localparam int NORM_EXP_W = 8;
  localparam int NORM_POS_W = $clog2(NORM_WIDTH);

  // Payload leaving the coarse stage; fine holds the residual shift in_pos[1:0].
  typedef struct packed {
    logic [NORM_WIDTH-1:0] mant;
    logic [NORM_EXP_W-1:0] exp;
    logic                  zero;
    logic                  uflow;
    logic [1:0]            fine;
  } stage_t;

  typedef struct packed {
    logic [NORM_WIDTH-1:0] mant;
    logic [NORM_EXP_W-1:0] exp;
    logic                  zero;
    logic                  uflow;
  } result_t;

endpackage

`default_nettype wire

// File: rtl/norm_pipe_reg.sv
// ============================================================================
// norm_pipe_reg: single valid/ready register stage with full-rate pass-through.  Rev 1.0
// ============================================================================
`default_nettype none

module norm_pipe_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Loads when empty or when the current word leaves this cycle.
  assign in_ready  = ~r_valid | out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/norm_shift16.sv
// ============================================================================
// norm_shift16: two-stage normalizer, coarse shift + flags then fine shift + exponent.  Rev 1.0
// ============================================================================
`default_nettype none

module norm_shift16
  import norm_pkg::*;
#(
  parameter int WIDTH = NORM_WIDTH,
  parameter int EXP_W = NORM_EXP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_mant,
  input  logic [EXP_W-1:0]         in_exp,
  input  logic                     in_nz,
  input  logic [$clog2(WIDTH)-1:0] in_pos,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_mant,
  output logic [EXP_W-1:0]         out_exp,
  output logic                     out_zero,
  output logic                     out_uflow
);

  localparam int POS_W = $clog2(WIDTH);

  logic [POS_W-1:0] w_coarse_amt;
  logic [EXP_W:0]   w_coarse_diff;
  logic             w_uflow;
  logic             w_zero;
  stage_t           w_s1_d;
  stage_t           w_s1_q;
  result_t          w_s2_d;
  result_t          w_s2_q;
  logic             w_s1_valid;
  logic             w_s2_ready;

  assign w_coarse_amt  = {in_pos[POS_W-1:2], 2'b00};
  assign w_coarse_diff = {1'b0, in_exp} - {{(EXP_W+1-POS_W){1'b0}}, w_coarse_amt};

  // Total borrow of in_exp - in_pos: either the coarse step borrows, or the
  // remaining fine amount exceeds what is left.
  assign w_uflow = in_nz & (w_coarse_diff[EXP_W] |
                   (w_coarse_diff[EXP_W-1:0] < {{(EXP_W-2){1'b0}}, in_pos[1:0]}));
  assign w_zero  = ~in_nz | w_uflow;

  always_comb begin
    w_s1_d       = '0;
    w_s1_d.zero  = w_zero;
    w_s1_d.uflow = w_uflow;
    w_s1_d.fine  = in_pos[1:0];
    if (!w_zero) begin
      w_s1_d.mant = in_mant << w_coarse_amt;
      w_s1_d.exp  = w_coarse_diff[EXP_W-1:0];
    end
  end

  norm_pipe_reg #(
    .DATA_W ($bits(stage_t))
  ) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_s1_d),
    .out_valid (w_s1_valid),
    .out_ready (w_s2_ready),
    .out_data  (w_s1_q)
  );

  // Zero results keep mant/exp at 0; the fine subtract is skipped so exp cannot wrap.
  always_comb begin
    w_s2_d       = '0;
    w_s2_d.zero  = w_s1_q.zero;
    w_s2_d.uflow = w_s1_q.uflow;
    if (!w_s1_q.zero) begin
      w_s2_d.mant = w_s1_q.mant << w_s1_q.fine;
      w_s2_d.exp  = w_s1_q.exp - {{(EXP_W-2){1'b0}}, w_s1_q.fine};
    end
  end

  norm_pipe_reg #(
    .DATA_W ($bits(result_t))
  ) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_s1_valid),
    .in_ready  (w_s2_ready),
    .in_data   (w_s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_s2_q)
  );

  assign out_mant  = w_s2_q.mant;
  assign out_exp   = w_s2_q.exp;
  assign out_zero  = w_s2_q.zero;
  assign out_uflow = w_s2_q.uflow;

endmodule

`default_nettype wire

// File: tb/tb_norm_shift16.sv
// ============================================================================
// tb_norm_shift16: randomized and directed bench with a queue-based reference model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_norm_shift16;

  typedef struct packed {
    logic [15:0] m;
    logic [7:0]  e;
    logic        z;
    logic        u;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mant;
  logic [7:0]  in_exp;
  logic        in_nz;
  logic [3:0]  in_pos;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_zero;
  logic        out_uflow;

  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  int   out_count = 0;
  res_t exp_q[$];
  bit   prev_stall = 1'b0;
  res_t prev_out;

  always #5 clk = ~clk;

  norm_shift16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .in_nz     (in_nz),
    .in_pos    (in_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_zero  (out_zero),
    .out_uflow (out_uflow)
  );

  // Reference: normalize by plain integer arithmetic.
  function automatic res_t model(input logic [15:0] m, input logic [7:0] e,
                                 input logic nz, input logic [3:0] p);
    res_t r;
    int   ie = int'(e);
    int   ip = int'(p);
    int   sh = int'(m) * (1 << ip);
    r = '0;
    if (!nz) begin
      r.z = 1'b1;
    end else if (ie < ip) begin
      r.z = 1'b1;
      r.u = 1'b1;
    end else begin
      r.m = 16'(sh % 65536);
      r.e = 8'(ie - ip);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with inputs already driven; samples, then advances one cycle.
  task automatic tick(output bit fired);
    res_t cur;
    res_t e;
    #1;
    fired = in_valid && in_ready;
    cur = '{m: out_mant, e: out_exp, z: out_zero, u: out_uflow};
    if (prev_stall) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data", 32'(cur), 32'(prev_out));
    end
    if (out_valid && out_ready) begin
      out_count++;
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_mant", 32'(out_mant), 32'(e.m));
        chk("out_exp", 32'(out_exp), 32'(e.e));
        chk("out_zero", 32'(out_zero), 32'(e.z));
        chk("out_uflow", 32'(out_uflow), 32'(e.u));
      end
    end
    if (fired) exp_q.push_back(model(in_mant, in_exp, in_nz, in_pos));
    prev_stall = out_valid && !out_ready;
    prev_out   = cur;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] m, input logic [7:0] e,
                      input logic nz, input logic [3:0] p);
    bit f;
    int n = 0;
    in_valid = 1'b1;
    in_mant  = m;
    in_exp   = e;
    in_nz    = nz;
    in_pos   = p;
    do begin
      tick(f);
      n++;
    end while (!f && n < 50);
    if (!f) chk("send_timeout", 32'(f), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit f;
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      tick(f);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic rand_word(output logic [15:0] m, output logic [7:0] e,
                           output logic nz, output logic [3:0] p);
    m  = 16'($urandom);
    nz = (($urandom % 8) != 0);
    p  = 4'($urandom % 16);
    e  = (($urandom % 4) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom % 256);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          f;
    int          start;
    int          sent;
    logic [15:0] bm [32];
    logic [7:0]  be [32];
    logic        bn [32];
    logic [3:0]  bp [32];

    rst_n = 1'b0; in_valid = 1'b0; in_mant = '0; in_exp = '0;
    in_nz = 1'b0; in_pos = '0; out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_mant", 32'(out_mant), 0);
    chk("rst_out_exp", 32'(out_exp), 0);
    chk("rst_out_zero", 32'(out_zero), 0);
    chk("rst_out_uflow", 32'(out_uflow), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset accepts; exact 2-cycle latency with known values
    in_valid = 1'b1; in_mant = 16'h00F0; in_exp = 8'd20; in_nz = 1'b1; in_pos = 4'd8;
    tick(f);
    chk("first_accept", 32'(f), 1);
    in_valid = 1'b0;
    #1 chk("lat1_valid", 32'(out_valid), 0);
    tick(f);
    #1;
    chk("lat2_valid", 32'(out_valid), 1);
    chk("norm_mant_const", 32'(out_mant), 32'h0000_F000);
    chk("norm_exp_const", 32'(out_exp), 12);
    tick(f);
    drain();

    // Directed corner vectors
    send(16'h0000, 8'd50, 1'b0, 4'd15);
    send(16'h0001, 8'd14, 1'b1, 4'd15);
    send(16'h0001, 8'd15, 1'b1, 4'd15);
    send(16'h1234, 8'd77, 1'b1, 4'd0);
    send(16'h0100, 8'd7,  1'b1, 4'd7);
    send(16'hFFFF, 8'd255, 1'b1, 4'd0);
    send(16'h0003, 8'd0,  1'b1, 4'd1);
    drain();

    // Backpressure: out_ready low on cycles 3..7
    for (int i = 0; i < 6; i++) rand_word(bm[i], be[i], bn[i], bp[i]);
    start = out_count;
    sent  = 0;
    for (int c = 0; c < 40 && (sent < 6 || exp_q.size() != 0 || out_valid); c++) begin
      out_ready = !(c >= 3 && c <= 7);
      if (sent < 6) begin
        in_valid = 1'b1; in_mant = bm[sent]; in_exp = be[sent];
        in_nz = bn[sent]; in_pos = bp[sent];
      end else begin
        in_valid = 1'b0;
      end
      if (c == 7) begin
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
      end
      tick(f);
      if (f) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent", 32'(sent), 6);
    chk("bp_delivered", 32'(out_count - start), 6);

    // Full rate: 32 back-to-back words
    for (int i = 0; i < 32; i++) rand_word(bm[i], be[i], bn[i], bp[i]);
    start = out_count;
    for (int i = 0; i < 34; i++) begin
      if (i < 32) begin
        in_valid = 1'b1; in_mant = bm[i]; in_exp = be[i]; in_nz = bn[i]; in_pos = bp[i];
      end else begin
        in_valid = 1'b0;
      end
      if (i >= 2) begin
        #1 chk("fr_out_valid", 32'(out_valid), 1);
      end
      tick(f);
      if (i < 32) chk("fr_accept", 32'(f), 1);
    end
    chk("fr_delivered", 32'(out_count - start), 32);
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    rand_word(in_mant, in_exp, in_nz, in_pos);
    in_valid = 1'b1;
    tick(f);
    rand_word(in_mant, in_exp, in_nz, in_pos);
    tick(f);
    in_valid = 1'b0;
    #1 chk("pre_rst_in_ready", 32'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_out_mant", 32'(out_mant), 0);
    chk("arst_out_zero", 32'(out_zero), 0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("post_rst_idle", 32'(out_valid), 0);
      tick(f);
    end
    start = out_count;
    send(16'h0F00, 8'd9, 1'b1, 4'd4);
    drain();
    chk("post_rst_delivered", 32'(out_count - start), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
